// File: rtl/dvp_frame_dma.sv
// dvp_frame_dma: writes the DVP pixel-word stream into memory as AXI4 INCR bursts, one burst outstanding
module dvp_frame_dma #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 32,
    parameter int MST_ID_W          = 5,
    parameter int MST_ID            = 0,
    parameter int TRANS_DATA_LEN_W  = 8,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RESP_W      = 2,
    parameter int BURST_LEN         = 16,
    parameter int FRAME_BEATS       = 19200
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dvp_en_i,
    input  logic [ADDR_W-1:0]            pxl_mem_base_i,
    input  logic                         frame_start_i,
    input  logic [DATA_W-1:0]            pxl_data_i,
    input  logic                         pxl_valid_i,
    output logic                         pxl_ready_o,
    output logic [MST_ID_W-1:0]          m_awid_o,
    output logic [ADDR_W-1:0]            m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0]  m_awlen_o,
    output logic [TRANS_DATA_SIZE_W-1:0] m_awsize_o,
    output logic                         m_awvalid_o,
    input  logic                         m_awready_i,
    output logic [DATA_W-1:0]            m_wdata_o,
    output logic                         m_wlast_o,
    output logic                         m_wvalid_o,
    input  logic                         m_wready_i,
    input  logic [TRANS_RESP_W-1:0]      m_bresp_i,
    input  logic                         m_bvalid_i,
    output logic                         m_bready_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         err_o
);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(FRAME_BEATS + 1);
    localparam int SH = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {IDLE, ARM, ADDR, DATA, RESP, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     remain, nxt_rem;
    logic [LW-1:0]     len, nxt_len, beat_cnt;
    logic              aw_hs, w_hs, b_hs, last;

    // The next burst length is taken from the full frame when arming, else from what is left
    assign nxt_rem = (state == ARM) ? RW'(FRAME_BEATS) : remain;
    assign nxt_len = (32'(nxt_rem) >= BURST_LEN) ? LW'(BURST_LEN) : LW'(nxt_rem);

    assign m_awid_o    = MST_ID_W'(MST_ID);
    assign m_awsize_o  = TRANS_DATA_SIZE_W'(SH);
    assign m_awaddr_o  = addr;
    assign m_wdata_o   = pxl_data_i;
    assign last        = beat_cnt == len - LW'(1);
    assign m_wvalid_o  = (state == DATA) & pxl_valid_i;
    assign pxl_ready_o = (state == DATA) & m_wready_i;
    assign m_wlast_o   = (state == DATA) & last;
    assign aw_hs       = m_awvalid_o & m_awready_i;
    assign w_hs        = m_wvalid_o & m_wready_i;
    assign b_hs        = m_bready_o & m_bvalid_i;

    // Frame/burst sequencer with registered AW/B handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            remain       <= '0;
            len          <= '0;
            beat_cnt     <= '0;
            m_awlen_o    <= '0;
            m_awvalid_o  <= 1'b0;
            m_bready_o   <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: if (dvp_en_i) state <= ARM;
                ARM: begin
                    if (!dvp_en_i) begin
                        state <= IDLE;
                    end else if (frame_start_i) begin
                        state       <= ADDR;
                        addr        <= pxl_mem_base_i;
                        remain      <= nxt_rem;
                        len         <= nxt_len;
                        m_awlen_o   <= TRANS_DATA_LEN_W'(nxt_len - LW'(1));
                        m_awvalid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        err_o       <= 1'b0;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state       <= DATA;
                        m_awvalid_o <= 1'b0;
                        beat_cnt    <= '0;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + LW'(1);
                        remain   <= remain - RW'(1);
                        if (last) begin
                            state      <= RESP;
                            m_bready_o <= 1'b1;
                            addr       <= addr + (ADDR_W'(len) << SH);
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        m_bready_o <= 1'b0;
                        if (m_bresp_i != '0) err_o <= 1'b1;
                        if (remain == '0) begin
                            state        <= DONE;
                            frame_done_o <= 1'b1;
                        end else if (!dvp_en_i) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state       <= ADDR;
                            len         <= nxt_len;
                            m_awlen_o   <= TRANS_DATA_LEN_W'(nxt_len - LW'(1));
                            m_awvalid_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= dvp_en_i ? ARM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dvp_frame_dma.sv
// tb_dvp_frame_dma: directed frame scenarios with random pixel data against a burst-list reference model
module tb_dvp_frame_dma;
    localparam int BL = 4;
    localparam int F  = 10;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dvp_en_i = 1'b0;
    logic [31:0] pxl_mem_base_i = BASE;
    logic        frame_start_i = 1'b0;
    logic [31:0] pxl_data_i = '0;
    logic        pxl_valid_i = 1'b0;
    logic        pxl_ready_o;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic [2:0]  m_awsize_o;
    logic        m_awvalid_o;
    logic        m_awready_i = 1'b1;
    logic [31:0] m_wdata_o;
    logic        m_wlast_o;
    logic        m_wvalid_o;
    logic        m_wready_i = 1'b1;
    logic [1:0]  m_bresp_i = '0;
    logic        m_bvalid_i = 1'b0;
    logic        m_bready_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    int b_cnt = 0;
    int done_cnt = 0;
    int err_burst = -1;
    bit gaps = 1'b0;
    bit toggle = 1'b0;

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] px_q[$];
    int          last_q[$];

    dvp_frame_dma #(.BURST_LEN(BL), .FRAME_BEATS(F)) dut (
        .clk(clk), .rst_n(rst_n), .dvp_en_i(dvp_en_i), .pxl_mem_base_i(pxl_mem_base_i),
        .frame_start_i(frame_start_i), .pxl_data_i(pxl_data_i), .pxl_valid_i(pxl_valid_i),
        .pxl_ready_o(pxl_ready_o), .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o),
        .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o), .m_awvalid_o(m_awvalid_o),
        .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i),
        .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    // Pixel source, AXI slave and transaction monitor: sample at negedge, drive 1 after posedge
    initial begin
        bit aw_f, w_f, b_f, last_f;
        forever begin
            @(negedge clk);
            aw_f   = m_awvalid_o & m_awready_i;
            w_f    = m_wvalid_o & m_wready_i;
            b_f    = m_bvalid_i & m_bready_o;
            last_f = m_wlast_o;
            if (rst_n) begin
                if (aw_f) begin
                    aw_addr_q.push_back(m_awaddr_o);
                    aw_len_q.push_back(m_awlen_o);
                end
                if (w_f) begin
                    w_q.push_back(m_wdata_o);
                    if (last_f) last_q.push_back(w_q.size() - 1);
                end
                if (b_f) b_cnt++;
                if (frame_done_o) done_cnt++;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_bvalid_i = 1'b0;
                m_wready_i = 1'b1;
            end else begin
                if (w_f && px_q.size() > 0) void'(px_q.pop_front());
                if (b_f) m_bvalid_i = 1'b0;
                if (w_f && last_f) begin
                    m_bvalid_i = 1'b1;
                    m_bresp_i  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
                end
                m_wready_i = toggle ? ~m_wready_i : 1'b1;
            end
            pxl_valid_i = (px_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
            pxl_data_i  = (px_q.size() > 0) ? px_q[0] : $urandom();
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input bit counting);
        aw_addr_q.delete();
        aw_len_q.delete();
        w_q.delete();
        last_q.delete();
        sent_q.delete();
        b_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < F; i++) sent_q.push_back(counting ? 32'(i) : $urandom());
        px_q = sent_q;
        dvp_en_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_start_i = 1'b1;
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        chk("awvalid_after_start", m_awvalid_o, 1);
        chk("awaddr_after_start", m_awaddr_o, BASE);
        chk("err_cleared_at_start", err_o, 0);
        chk("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int cnt);
        int n = 0;
        while (w_q.size() < cnt && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("beats_reached", w_q.size() >= cnt, 1);
    endtask

    // Expected bursts follow from splitting the frame into BL-beat chunks starting at base
    task automatic check_frame(input logic [31:0] base, input logic exp_err);
        int k = 0;
        chk("aw_count", aw_addr_q.size(), (F + BL - 1) / BL);
        chk("wlast_count", last_q.size(), (F + BL - 1) / BL);
        chk("beat_count", w_q.size(), F);
        for (int off = 0; off < F; off += BL) begin
            int n = (F - off < BL) ? F - off : BL;
            if (k < aw_addr_q.size()) begin
                chk("aw_addr", aw_addr_q[k], base + 32'(4 * off));
                chk("aw_len", aw_len_q[k], 8'(n - 1));
            end
            if (k < last_q.size()) chk("wlast_beat", last_q[k], off + n - 1);
            k++;
        end
        for (int i = 0; i < F && i < w_q.size(); i++) chk("wdata", w_q[i], sent_q[i]);
        chk("frame_done_cycles", done_cnt, 1);
        chk("err_after_frame", err_o, exp_err);
        chk("busy_after_frame", busy_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", m_awvalid_o, 0);
        chk("rst_wvalid", m_wvalid_o, 0);
        chk("rst_wlast", m_wlast_o, 0);
        chk("rst_pxl_ready", pxl_ready_o, 0);
        chk("rst_bready", m_bready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_awaddr", m_awaddr_o, 0);
        chk("rst_awlen", m_awlen_o, 0);
        chk("awid", m_awid_o, 0);
        chk("awsize", m_awsize_o, 2);
        rst_n = 1'b1;

        start_frame(1'b1);
        wait_done();
        check_frame(BASE, 1'b0);

        gaps = 1'b1;
        toggle = 1'b1;
        start_frame(1'b0);
        wait_done();
        check_frame(BASE, 1'b0);
        gaps = 1'b0;
        toggle = 1'b0;

        err_burst = 1;
        start_frame(1'b0);
        wait_done();
        check_frame(BASE, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("err_sticky_in_arm", err_o, 1);
        err_burst = -1;

        start_frame(1'b0);
        wait_beats(1);
        #1;
        frame_start_i = 1'b1;
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        wait_done();
        check_frame(BASE, 1'b0);

        start_frame(1'b0);
        wait_beats(1);
        #1;
        dvp_en_i = 1'b0;
        begin
            int n = 0;
            while (b_cnt == 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        chk("drop_aw_count", aw_addr_q.size(), 1);
        chk("drop_beats", w_q.size(), BL);
        chk("drop_wlast_count", last_q.size(), 1);
        if (last_q.size() > 0) chk("drop_wlast_beat", last_q[0], BL - 1);
        chk("drop_b_count", b_cnt, 1);
        for (int i = 0; i < BL && i < w_q.size(); i++) chk("drop_wdata", w_q[i], sent_q[i]);
        chk("drop_no_done", done_cnt, 0);
        chk("drop_busy", busy_o, 0);
        chk("drop_awvalid", m_awvalid_o, 0);
        px_q.delete();

        start_frame(1'b0);
        wait_beats(2);
        #1;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_awvalid", m_awvalid_o, 0);
        chk("mid_rst_wvalid", m_wvalid_o, 0);
        chk("mid_rst_wlast", m_wlast_o, 0);
        chk("mid_rst_pxl_ready", pxl_ready_o, 0);
        chk("mid_rst_bready", m_bready_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", frame_done_o, 0);
        px_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_frame(1'b0);
        wait_done();
        check_frame(BASE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
